inst_mem_responder: RTL and testbench
=====================================

Name: inst_mem_responder

Overview:
- Instruction-memory responder serving the fetch stage: accepts a PC fetch request and returns the 32-bit instruction after a fixed, parameterised latency.
- Drives mem_busy, which the top level routes into the pipeline freeze, so the fetch PC holds while an access is outstanding.
- Program image is written through a separate load port before or during execution.
- Supports flush abort of an in-flight access on a taken branch.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- LATENCY, 3, cycles from request cycle to inst_valid cycle; legal range 1..15.
- NOP_WORD, 32'hE1A00000, instruction returned for out-of-range PCs (MOV r0,r0).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request; pc is valid this cycle
- pc  input  32  byte address of the instruction to fetch
- flush  input  1  abort any pending access (branch taken)
- load_en  input  1  write enable for the program-load port
- load_addr  input  ADDR_W  word address for the load write
- load_data  input  32  word written at load_addr
- instruction  output  32  fetched instruction; registered
- resp_pc  output  32  PC that the returned instruction belongs to; registered
- inst_valid  output  1  instruction/resp_pc valid; one-cycle pulse
- mem_busy  output  1  access outstanding; drives pipeline freeze

Behaviour:
- Reset (sync, rst=1 at rising edge): state=IDLE, cnt=0, instruction=0, resp_pc=0, inst_valid=0. mem_busy=0 while rst is held. Memory array is not cleared. Reset mid-access silently drops the access.
- Address decode: word index = pc[ADDR_W+1:2]; pc[1:0] ignored. If pc[31:ADDR_W+2] != 0, the returned data is NOP_WORD.
- FSM states IDLE, WAIT, RESP. inst_valid = (state==RESP).
- IDLE:
  - req_valid & ~flush: latch pc into addr_q, set cnt = LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
  - flush drops a same-cycle request; state stays IDLE.
- WAIT:
  - flush: go to IDLE, no response.
  - Otherwise cnt decrements each cycle. When cnt==1, go to RESP and register instruction = mem[addr_q] (or NOP_WORD) and resp_pc = addr_q.
  - req_valid is ignored in WAIT.
- RESP:
  - Lasts exactly one cycle, then always goes to IDLE.
  - req_valid in RESP is ignored; the fetch stage presents the next PC in the following IDLE cycle.
  - flush in RESP does not suppress inst_valid in that cycle; the downstream register discards it.
- Latency: request sampled in cycle c gives inst_valid high in cycle c+LATENCY. Throughput is one fetch per LATENCY+1 cycles.
- mem_busy = ~flush & ((state==WAIT) | (state==IDLE & req_valid)). This is combinational, so freeze is high in the request cycle itself; it is low in RESP.
- Load port:
  - Write takes effect at the rising edge when load_en=1, independent of the FSM.
  - A write to addr_q at the same edge as the RESP-entry read returns the OLD word (read-before-write).
  - A write at any earlier edge is visible.
- instruction/resp_pc hold their last value outside RESP (not cleared on IDLE).

Test Plan:
- Reset then fetch, LATENCY=3, ADDR_W=8. Load mem[2]=32'hE3A01005, then req_valid with pc=8 in cycle c.
  -> mem_busy=1 in c, c+1, c+2; inst_valid=1 only in c+3 with instruction=E3A01005 and resp_pc=8; back to IDLE in c+4.
- LATENCY=1, back-to-back fetches at pc=0 then pc=4, each presented in an IDLE cycle, with mem[0]=11111111 and mem[1]=22222222.
  -> responses 11111111 and 22222222, each one cycle after its request; mem_busy high only in the request cycles.
- Flush abort, LATENCY=3: request pc=12, assert flush in c+1.
  -> state IDLE in c+2, no inst_valid through c+5, mem_busy=0 from c+1 on; a new request pc=16 then completes normally.
- Out-of-range address: pc=32'h00000400 with ADDR_W=8.
  -> inst_valid after LATENCY cycles with instruction=E1A00000 and resp_pc=00000400.
- Read-before-write collision, LATENCY=2: mem[3]=AAAAAAAA, request pc=12, load_en writing BBBBBBBB to addr 3 at the RESP-entry edge.
  -> instruction=AAAAAAAA; a re-fetch of pc=12 returns BBBBBBBB.
- Reset mid-access: rst=1 during WAIT.
  -> next cycle inst_valid=0, mem_busy=0, instruction=0; memory contents preserved on a later fetch.

Source files
------------

// File: rtl/inst_mem_responder_if.sv
// Fetch-side bus between the fetch stage and the instruction memory:
// request/flush, program-load port, and registered response plus busy.
interface inst_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic [31:0]       pc;
  logic              flush;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [31:0]       instruction;
  logic [31:0]       resp_pc;
  logic              inst_valid;
  logic              mem_busy;

  modport master (
    output req_valid,
    output pc,
    output flush,
    output load_en,
    output load_addr,
    output load_data,
    input  instruction,
    input  resp_pc,
    input  inst_valid,
    input  mem_busy
  );

  modport slave (
    input  req_valid,
    input  pc,
    input  flush,
    input  load_en,
    input  load_addr,
    input  load_data,
    output instruction,
    output resp_pc,
    output inst_valid,
    output mem_busy
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: fixed-latency fetch, flush abort, load port.
// Ports: clk, rst (sync, active-high), bus (slave side of the fetch bus).
module inst_mem_responder #(
  parameter int          ADDR_W   = 8,
  parameter int          LATENCY  = 3,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                clk,
  input  logic                rst,
  inst_mem_responder_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         SINGLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] addr_q;
  logic [31:0] addr_n;
  logic [31:0] ins_q;
  logic [31:0] rpc_q;

  logic        cap;
  logic [31:0] cap_pc;
  logic        oor;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0] rd_data;

  logic [31:0] mem [DEPTH];

  // With a single-cycle latency the read happens in the request cycle,
  // so the capture address comes straight from pc instead of addr_q.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    cap     = 1'b0;
    cap_pc  = addr_q;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          addr_n = bus.pc;
          cnt_n  = LAT_M1;
          cap_pc = bus.pc;
          if (SINGLE) begin
            state_n = RESP;
            cap     = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = RESP;
            cap     = 1'b1;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Upper PC bits beyond the array select the NOP instead of wrapping.
  assign oor      = (cap_pc >> (ADDR_W + 2)) != 32'd0;
  assign word_idx = cap_pc[ADDR_W+1:2];
  assign rd_data  = oor ? NOP_WORD : mem[word_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= 32'd0;
      ins_q  <= 32'd0;
      rpc_q  <= 32'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      if (cap) begin
        ins_q <= rd_data;
        rpc_q <= cap_pc;
      end
    end
  end

  // Read above samples the old word, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instruction = ins_q;
  assign bus.resp_pc     = rpc_q;
  assign bus.inst_valid  = (state == RESP);
  assign bus.mem_busy    = !rst && !bus.flush &&
                           ((state == WAIT) ||
                            (state == IDLE && bus.req_valid));

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: LATENCY 1, 2 and 3 side by side,
// directed scenarios then random traffic against a transaction model.
module tb_inst_mem_responder;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [31:0]   pc;
  logic          flush;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  logic        o_valid [3];
  logic        o_busy  [3];
  logic [31:0] o_ins   [3];
  logic [31:0] o_rpc   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    inst_mem_responder_if #(.ADDR_W(AW)) bus ();
    assign bus.req_valid = req_valid;
    assign bus.pc        = pc;
    assign bus.flush     = flush;
    assign bus.load_en   = load_en;
    assign bus.load_addr = load_addr;
    assign bus.load_data = load_data;
    assign o_valid[g]    = bus.inst_valid;
    assign o_busy[g]     = bus.mem_busy;
    assign o_ins[g]      = bus.instruction;
    assign o_rpc[g]      = bus.resp_pc;
    inst_mem_responder #(
      .ADDR_W  (AW),
      .LATENCY (g + 1),
      .NOP_WORD(NOP)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Transaction model: a fetch accepted in cycle c answers in c+L
  // with the word the array held just before the c+L edge's write.
  logic [31:0] mm [2**AW];
  bit          pend [3];
  int          due  [3];
  logic [31:0] maddr [3];
  logic [31:0] eins  [3];
  logic [31:0] epc   [3];
  int          cyc = 0;

  function automatic logic [31:0] look(input logic [31:0] a);
    logic [AW-1:0] w;
    w = a[AW+1:2];
    if ((a >> (AW + 2)) != 32'd0) return NOP;
    return mm[w];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        eins[k] = 32'd0;
        epc[k]  = 32'd0;
      end else if (pend[k] && cyc == due[k]) begin
        pend[k] = 1'b0;
      end else if (pend[k] && flush) begin
        pend[k] = 1'b0;
      end else if (!pend[k] && req_valid && !flush) begin
        pend[k]  = 1'b1;
        due[k]   = cyc + k + 1;
        maddr[k] = pc;
      end
      if (!rst && pend[k] && cyc + 1 == due[k]) begin
        eins[k] = look(maddr[k]);
        epc[k]  = maddr[k];
      end
    end
    if (load_en) mm[load_addr] = load_data;
    cyc++;
  endtask

  task automatic step(input logic          r,
                      input logic          rv,
                      input logic [31:0]   p,
                      input logic          f,
                      input logic          le,
                      input logic [AW-1:0] la,
                      input logic [31:0]   ld);
    logic ev;
    logic eb;
    rst       = r;
    req_valid = rv;
    pc        = p;
    flush     = f;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    #4;
    for (int k = 0; k < 3; k++) begin
      ev = pend[k] && cyc == due[k];
      eb = !r && !f &&
           ((pend[k] && cyc < due[k]) || (!pend[k] && rv));
      chk($sformatf("valid_L%0d", k + 1), 32'(o_valid[k]), 32'(ev));
      chk($sformatf("busy_L%0d", k + 1), 32'(o_busy[k]), 32'(eb));
      chk($sformatf("ins_L%0d", k + 1), o_ins[k], eins[k]);
      chk($sformatf("rpc_L%0d", k + 1), o_rpc[k], epc[k]);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] p);
    step(1'b0, 1'b1, p, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    logic          r;
    logic          rv;
    logic          f;
    logic          le;
    logic [31:0]   p;
    logic [AW-1:0] la;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      due[k]  = 0;
      maddr[k] = 32'd0;
      eins[k] = 32'd0;
      epc[k]  = 32'd0;
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    pc        = 32'd0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = 32'd0;
    @(posedge clk);
    #1;
    cyc = 1;
    step(1'b1, 1'b1, 32'd8, 1'b0, 1'b0, '0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);

    for (int i = 0; i < 2**AW; i++)
      load(AW'(i), $urandom);

    load(8'd2, 32'hE3A01005);
    load(8'd0, 32'h11111111);
    load(8'd1, 32'h22222222);
    load(8'd3, 32'hAAAAAAAA);

    fetch(32'd8);
    idle(5);

    fetch(32'd0);
    idle(1);
    fetch(32'd4);
    idle(5);

    fetch(32'd12);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, '0, 32'd0);
    idle(5);
    fetch(32'd16);
    idle(5);

    fetch(32'h00000400);
    idle(5);

    fetch(32'd12);
    load(8'd3, 32'hBBBBBBBB);
    idle(4);
    fetch(32'd12);
    idle(5);

    fetch(32'd8);
    idle(1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    idle(2);
    fetch(32'd8);
    idle(5);

    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      rv = $urandom_range(0, 1) == 1;
      f  = ($urandom_range(0, 9) == 0);
      le = ($urandom_range(0, 4) == 0);
      la = AW'($urandom_range(0, 2**AW - 1));
      if ($urandom_range(0, 7) == 0) p = $urandom;
      else p = 32'($urandom_range(0, 1023));
      step(r, rv, p, f, le, la, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
